// File: rtl/riscv_wb_nb.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb_nb
//  Purpose  : Non-blocking RV12 write-back stage. Up to DEPTH data-memory
//             accesses may be outstanding; instructions retire in program
//             order from a circular retirement queue, with load alignment,
//             memory-fault merging and younger-entry flush on exception.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_wb_nb #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200,
  parameter int              DEPTH   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid_i,
  input  logic [XLEN-1:0] mem_pc_i,
  input  logic [31:0]     mem_instr_i,
  input  logic            mem_exc_i,
  input  logic [3:0]      mem_cause_i,
  input  logic [XLEN-1:0] mem_r_i,
  input  logic [XLEN-1:0] mem_memadr_i,
  input  logic            dmem_ack_i,
  input  logic            dmem_err_i,
  input  logic            dmem_misaligned_i,
  input  logic            dmem_page_fault_i,
  input  logic [XLEN-1:0] dmem_q_i,
  output logic            wb_stall_o,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic [31:0]     wb_instr_o,
  output logic            wb_exc_o,
  output logic [3:0]      wb_cause_o,
  output logic [XLEN-1:0] wb_badaddr_o,
  output logic [4:0]      wb_dst_o,
  output logic [XLEN-1:0] wb_r_o,
  output logic            wb_we_o
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            OW   = 8;
  localparam int            SW   = (XLEN == 64) ? 3 : 2;
  localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_STORE_FP = 5'b01001;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;

  // Shift the raw read data down to the addressed byte, then extend by funct3.
  function automatic logic [XLEN-1:0] align_load(input logic [2:0]      funct3,
                                                 input logic [SW-1:0]   offset,
                                                 input logic [XLEN-1:0] data);
    logic [XLEN-1:0] s;
    s = data >> {offset, 3'b000};
    case (funct3)
      3'b000:  align_load = XLEN'($signed(s[7:0]));
      3'b001:  align_load = XLEN'($signed(s[15:0]));
      3'b010:  align_load = XLEN'($signed(s[31:0]));
      3'b100:  align_load = XLEN'(s[7:0]);
      3'b101:  align_load = XLEN'(s[15:0]);
      3'b110:  align_load = XLEN'(s[31:0]);
      default: align_load = s;
    endcase
  endfunction

  // Misaligned outranks page fault, which outranks access fault.
  function automatic logic [3:0] fault_cause(input logic is_store,
                                             input logic misaligned,
                                             input logic page_fault);
    if (misaligned)      fault_cause = is_store ? 4'd6  : 4'd4;
    else if (page_fault) fault_cause = is_store ? 4'd15 : 4'd13;
    else                 fault_cause = is_store ? 4'd7  : 4'd5;
  endfunction

  // Register write only for non-excepting instructions with a real destination.
  function automatic logic calc_we(input logic exc, input logic [31:0] instr);
    logic [4:0] op;
    op      = instr[6:2];
    calc_we = !exc && (instr[11:7] != 5'd0) && (op != OP_STORE) &&
              (op != OP_STORE_FP) && (op != OP_BRANCH) && (op != OP_MISC_MEM);
  endfunction

  // Retirement queue storage, indexed by physical slot.
  logic [XLEN-1:0] q_pc      [DEPTH];
  logic [31:0]     q_instr   [DEPTH];
  logic            q_exc     [DEPTH];
  logic [3:0]      q_cause   [DEPTH];
  logic [XLEN-1:0] q_badaddr [DEPTH];
  logic [XLEN-1:0] q_r       [DEPTH];
  logic            q_we      [DEPTH];
  logic            q_pend    [DEPTH];
  logic [XLEN-1:0] q_adr     [DEPTH];

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [OW-1:0]   orphan_cnt;
  logic            flush_q;

  logic            in_is_mem;
  logic            in_is_load;
  logic            in_we;
  logic [XLEN-1:0] in_badaddr;
  logic [XLEN-1:0] in_load_data;
  logic [3:0]      in_cause;
  logic            resp;
  logic            resp_fault;
  logic            resp_take;
  logic            retire_now;
  logic            flush;
  logic            accept;
  logic            bypass;
  logic            push;
  logic            rs_hit;
  logic [AW-1:0]   rs_slot;
  logic [AW-1:0]   scan_slot;
  logic [CW-1:0]   pend_left;
  logic            in_hit;
  logic            in_pend;
  logic [XLEN-1:0] rs_load_data;
  logic [3:0]      rs_cause;

  // Decode the incoming instruction and the handshake conditions for this cycle.
  always_comb begin
    in_is_load   = (mem_instr_i[6:2] == OP_LOAD);
    in_is_mem    = (in_is_load || (mem_instr_i[6:2] == OP_STORE)) && !mem_exc_i;
    in_we        = calc_we(mem_exc_i, mem_instr_i);
    in_badaddr   = (mem_exc_i && (mem_cause_i == 4'd2)) ? XLEN'(mem_instr_i) : '0;
    in_load_data = align_load(mem_instr_i[14:12], mem_memadr_i[SW-1:0], dmem_q_i);
    in_cause     = fault_cause(mem_instr_i[6:2] == OP_STORE, dmem_misaligned_i,
                               dmem_page_fault_i);
    resp         = dmem_ack_i | dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
    resp_fault   = dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
    resp_take    = resp && (orphan_cnt == '0);
    tail         = (head + AW'(count)) & MASK;
    retire_now   = (count != '0) && !q_pend[head];
    flush        = retire_now && q_exc[head];
    // The cycle after a flush MEM is being killed upstream, so nothing is taken.
    wb_stall_o   = mem_valid_i && (count == FULL) && !retire_now && !flush_q;
    accept       = mem_valid_i && !wb_stall_o && !flush_q;
    bypass       = accept && (count == '0) && !in_is_mem;
    push         = accept && !bypass && !flush;
  end

  // Find the oldest pending entry for a response and count the pending entries left over.
  always_comb begin
    rs_hit    = 1'b0;
    rs_slot   = '0;
    scan_slot = '0;
    pend_left = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_slot = (head + AW'(i)) & MASK;
      if ((CW'(i) < count) && q_pend[scan_slot]) begin
        if (resp_take && !rs_hit) begin
          rs_hit  = 1'b1;
          rs_slot = scan_slot;
        end else begin
          pend_left = pend_left + CW'(1);
        end
      end
    end
    // With no older access outstanding, the response belongs to the incoming one.
    in_hit       = resp_take && !rs_hit && accept && in_is_mem;
    in_pend      = accept && in_is_mem && !in_hit;
    rs_load_data = align_load(q_instr[rs_slot][14:12], q_adr[rs_slot][SW-1:0], dmem_q_i);
    rs_cause     = fault_cause(q_instr[rs_slot][6:2] == OP_STORE, dmem_misaligned_i,
                               dmem_page_fault_i);
  end

  // Queue pointers, occupancy and the count of responses owed to flushed accesses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head       <= '0;
      count      <= '0;
      orphan_cnt <= '0;
      flush_q    <= 1'b0;
    end else begin
      flush_q    <= flush;
      orphan_cnt <= orphan_cnt - OW'(resp && (orphan_cnt != '0))
                    + (flush ? (OW'(pend_left) + OW'(in_pend)) : '0);
      if (flush) begin
        head  <= '0;
        count <= '0;
      end else begin
        head  <= (head + AW'(retire_now)) & MASK;
        count <= count - CW'(retire_now) + CW'(push);
      end
    end
  end

  // Queue payload: write the new tail entry and merge responses into their entries.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_pc[tail]      <= mem_pc_i;
      q_instr[tail]   <= mem_instr_i;
      q_adr[tail]     <= mem_memadr_i;
      q_r[tail]       <= mem_r_i;
      q_exc[tail]     <= mem_exc_i;
      q_cause[tail]   <= mem_cause_i;
      q_badaddr[tail] <= in_badaddr;
      q_we[tail]      <= in_we;
      q_pend[tail]    <= in_is_mem && !in_hit;
      if (in_hit) begin
        if (resp_fault) begin
          q_exc[tail]     <= 1'b1;
          q_cause[tail]   <= in_cause;
          q_badaddr[tail] <= mem_memadr_i;
          q_we[tail]      <= 1'b0;
        end else if (in_is_load) begin
          q_r[tail] <= in_load_data;
        end
      end
    end
    if (rs_hit) begin
      q_pend[rs_slot] <= 1'b0;
      if (resp_fault) begin
        q_exc[rs_slot]     <= 1'b1;
        q_cause[rs_slot]   <= rs_cause;
        q_badaddr[rs_slot] <= q_adr[rs_slot];
        q_we[rs_slot]      <= 1'b0;
      end else if (q_instr[rs_slot][6:2] == OP_LOAD) begin
        q_r[rs_slot] <= rs_load_data;
      end
    end
  end

  // Output registers: retire the queue head, or bypass a ready instruction into an empty queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o   <= 1'b0;
      wb_pc_o      <= PC_INIT;
      wb_instr_o   <= '0;
      wb_exc_o     <= 1'b0;
      wb_cause_o   <= '0;
      wb_badaddr_o <= '0;
      wb_dst_o     <= '0;
      wb_r_o       <= '0;
      wb_we_o      <= 1'b0;
    end else if (retire_now) begin
      wb_valid_o   <= 1'b1;
      wb_pc_o      <= q_pc[head];
      wb_instr_o   <= q_instr[head];
      wb_exc_o     <= q_exc[head];
      wb_cause_o   <= q_cause[head];
      wb_badaddr_o <= q_badaddr[head];
      wb_dst_o     <= q_instr[head][11:7];
      wb_r_o       <= q_r[head];
      wb_we_o      <= q_we[head];
    end else if (bypass) begin
      wb_valid_o   <= 1'b1;
      wb_pc_o      <= mem_pc_i;
      wb_instr_o   <= mem_instr_i;
      wb_exc_o     <= mem_exc_i;
      wb_cause_o   <= mem_cause_i;
      wb_badaddr_o <= in_badaddr;
      wb_dst_o     <= mem_instr_i[11:7];
      wb_r_o       <= mem_r_i;
      wb_we_o      <= in_we;
    end else begin
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb_nb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_wb_nb
//  Purpose  : Self-checking bench for riscv_wb_nb (XLEN=32, DEPTH=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_wb_nb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = '0;
  logic [31:0] mem_instr = '0;
  logic        mem_exc = 1'b0;
  logic [3:0]  mem_cause = '0;
  logic [31:0] mem_r = '0;
  logic [31:0] mem_memadr = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_err = 1'b0;
  logic        dmem_mis = 1'b0;
  logic        dmem_pf = 1'b0;
  logic [31:0] dmem_q = '0;
  logic        wb_stall;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        wb_exc;
  logic [3:0]  wb_cause;
  logic [31:0] wb_badaddr;
  logic [4:0]  wb_dst;
  logic [31:0] wb_r;
  logic        wb_we;

  riscv_wb_nb #(.XLEN(32), .PC_INIT(32'h200), .DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_instr_i(mem_instr),
    .mem_exc_i(mem_exc), .mem_cause_i(mem_cause), .mem_r_i(mem_r),
    .mem_memadr_i(mem_memadr),
    .dmem_ack_i(dmem_ack), .dmem_err_i(dmem_err), .dmem_misaligned_i(dmem_mis),
    .dmem_page_fault_i(dmem_pf), .dmem_q_i(dmem_q),
    .wb_stall_o(wb_stall), .wb_valid_o(wb_valid), .wb_pc_o(wb_pc),
    .wb_instr_o(wb_instr), .wb_exc_o(wb_exc), .wb_cause_o(wb_cause),
    .wb_badaddr_o(wb_badaddr), .wb_dst_o(wb_dst), .wb_r_o(wb_r), .wb_we_o(wb_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] badaddr;
    logic [4:0]  dst;
    logic [31:0] r;
    logic        we;
  } ret_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r;
    logic        exc;
    logic [3:0]  cause;
    logic        exp_we;
    logic [31:0] exp_bad;
  } vec_t;

  ret_t exp_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void expect_ret(input logic [31:0] pc, input logic [31:0] instr,
                                     input logic exc, input logic [3:0] cause,
                                     input logic [31:0] bad, input logic [31:0] r,
                                     input logic we);
    ret_t e;
    e.pc = pc; e.instr = instr; e.exc = exc; e.cause = cause;
    e.badaddr = bad; e.dst = instr[11:7]; e.r = r; e.we = we;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Drive one instruction at posedge+1 and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic exc,
                      input logic [3:0] cause, input logic [31:0] r, input logic [31:0] adr);
    int guard;
    guard = 0;
    mem_valid = 1'b1; mem_pc = pc; mem_instr = instr; mem_exc = exc;
    mem_cause = cause; mem_r = r; mem_memadr = adr;
    #1;
    while (wb_stall && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL stall_timeout: pc %h never accepted", pc);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  // One-cycle data-memory response.
  task automatic resp(input logic ack, input logic err, input logic mis, input logic pf,
                      input logic [31:0] q);
    dmem_ack = ack; dmem_err = err; dmem_mis = mis; dmem_pf = pf; dmem_q = q;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_err = 1'b0; dmem_mis = 1'b0; dmem_pf = 1'b0;
  endtask

  // Wait (bounded) for all expected retirements, then settle a couple of cycles.
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d retirements outstanding", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every retirement is matched against the oldest expectation.
  always @(negedge clk) begin
    ret_t act;
    ret_t e;
    if (!rst && wb_valid) begin
      n_cmp++;
      act = {wb_pc, wb_instr, wb_exc, wb_cause, wb_badaddr, wb_dst, wb_r, wb_we};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL retire_unexpected: pc %h instr %h, want no retire", wb_pc, wb_instr);
      end else begin
        e = exp_q.pop_front();
        if (e.exc) act.r = e.r;
        if (act !== e) begin
          n_err++;
          $display("FAIL retire pc %h: got exc=%b cause=%0d bad=%h dst=%0d r=%h we=%b pc=%h, want exc=%b cause=%0d bad=%h dst=%0d r=%h we=%b pc=%h",
                   e.pc, act.exc, act.cause, act.badaddr, act.dst, act.r, act.we, act.pc,
                   e.exc, e.cause, e.badaddr, e.dst, e.r, e.we, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0293, 32'h0000_1234, 1'b0, 4'd0, 1'b1, 32'h0};          // ADDI x5
    vecs[1] = '{32'h0000_0033, 32'h0000_0077, 1'b0, 4'd0, 1'b0, 32'h0};          // ADD x0
    vecs[2] = '{32'h0000_0537, 32'hABCD_0000, 1'b0, 4'd0, 1'b1, 32'h0};          // LUI x10
    vecs[3] = '{32'h0000_02E3, 32'h0000_0001, 1'b0, 4'd0, 1'b0, 32'h0};          // BEQ
    vecs[4] = '{32'h0000_008F, 32'h0000_0002, 1'b0, 4'd0, 1'b0, 32'h0};          // FENCE
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 4'd2, 1'b0, 32'hFFFF_FFFF};  // illegal
    vecs[6] = '{32'h0000_0F93, 32'h0000_0004, 1'b1, 4'd3, 1'b0, 32'h0};          // ADDI x31, breakpoint
    vecs[7] = '{32'h0000_00EF, 32'h0000_0304, 1'b0, 4'd0, 1'b1, 32'h0};          // JAL x1
    vecs[8] = '{32'h0000_2183, 32'h0000_0005, 1'b1, 4'd4, 1'b0, 32'h0};          // LW, upstream fault

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_pc", wb_pc, 32'h200);
    check("rst_valid", 32'(wb_valid), 32'h0);
    check("rst_we", 32'(wb_we), 32'h0);
    check("rst_stall", 32'(wb_stall), 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("idle_no_retire", 32'(wb_valid), 32'h0);

    // Single ALU instruction: one-cycle latency through the empty queue
    expect_ret(32'h1000, 32'h0000_0293, 1'b0, 4'd0, 32'h0, 32'h1234, 1'b1);
    send(32'h1000, 32'h0000_0293, 1'b0, 4'd0, 32'h1234, 32'h0);
    check("bypass_latency", 32'(wb_valid), 32'h1);
    check("bypass_r", wb_r, 32'h1234);

    // Table of ready instructions
    for (int i = 0; i < 9; i++) begin
      expect_ret(32'h2000 + 32'(4 * i), vecs[i].instr, vecs[i].exc, vecs[i].cause,
                 vecs[i].exp_bad, vecs[i].r, vecs[i].exp_we);
      send(32'h2000 + 32'(4 * i), vecs[i].instr, vecs[i].exc, vecs[i].cause, vecs[i].r, 32'h0);
    end
    drain();

    // Two outstanding loads, third instruction stalls until the first retires
    expect_ret(32'h3000, 32'h0000_0083, 1'b0, 4'd0, 32'h0, 32'h0000_007F, 1'b1);
    expect_ret(32'h3004, 32'h0000_5103, 1'b0, 4'd0, 32'h0, 32'h0000_8081, 1'b1);
    expect_ret(32'h3008, 32'h0000_0493, 1'b0, 4'd0, 32'h0, 32'h0000_0099, 1'b1);
    send(32'h3000, 32'h0000_0083, 1'b0, 4'd0, 32'h0, 32'h101);
    send(32'h3004, 32'h0000_5103, 1'b0, 4'd0, 32'h0, 32'h102);
    fork
      send(32'h3008, 32'h0000_0493, 1'b0, 4'd0, 32'h99, 32'h0);
      begin
        #2;
        check("full_stall", 32'(wb_stall), 32'h1);
        repeat (3) @(posedge clk); #1;
        check("full_stall_held", 32'(wb_stall), 32'h1);
        resp(1'b1, 1'b0, 1'b0, 1'b0, 32'h8081_7F00);
        resp(1'b1, 1'b0, 1'b0, 1'b0, 32'h8081_7F00);
      end
    join
    drain();

    // Access fault on the older load flushes the younger one; its ack is dropped
    expect_ret(32'h4000, 32'h0000_2183, 1'b1, 4'd5, 32'h100, 32'h0, 1'b0);
    send(32'h4000, 32'h0000_2183, 1'b0, 4'd0, 32'h0, 32'h100);
    send(32'h4004, 32'h0000_2203, 1'b0, 4'd0, 32'h0, 32'h104);
    resp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk); #1;
    expect_ret(32'h4008, 32'h0000_2383, 1'b0, 4'd0, 32'h0, 32'h1122_3344, 1'b1);
    send(32'h4008, 32'h0000_2383, 1'b0, 4'd0, 32'h0, 32'h200);
    resp(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    resp(1'b1, 1'b0, 1'b0, 1'b0, 32'h1122_3344);
    expect_ret(32'h400C, 32'h0000_0313, 1'b0, 4'd0, 32'h0, 32'h0000_0066, 1'b1);
    send(32'h400C, 32'h0000_0313, 1'b0, 4'd0, 32'h66, 32'h0);
    drain();

    // Store, misaligned load, store page fault
    expect_ret(32'h5000, 32'h0000_2423, 1'b0, 4'd0, 32'h0, 32'h0000_0077, 1'b0);
    send(32'h5000, 32'h0000_2423, 1'b0, 4'd0, 32'h77, 32'h300);
    resp(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drain();
    expect_ret(32'h5004, 32'h0000_2283, 1'b1, 4'd4, 32'h103, 32'h0, 1'b0);
    send(32'h5004, 32'h0000_2283, 1'b0, 4'd0, 32'h0, 32'h103);
    resp(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    drain();
    expect_ret(32'h5008, 32'h0000_2423, 1'b1, 4'd15, 32'h404, 32'h0, 1'b0);
    send(32'h5008, 32'h0000_2423, 1'b0, 4'd0, 32'h0, 32'h404);
    resp(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    drain();

    // Reset with two loads in flight, late acks afterwards
    send(32'h6000, 32'h0000_2403, 1'b0, 4'd0, 32'h0, 32'h100);
    send(32'h6004, 32'h0000_2483, 1'b0, 4'd0, 32'h0, 32'h104);
    mem_valid = 1'b1; mem_instr = 32'h0000_0513;
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(wb_stall), 32'h0);
    check("midrst_pc", wb_pc, 32'h200);
    check("midrst_valid", 32'(wb_valid), 32'h0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    resp(1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD0_BAD0);
    resp(1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD1_BAD1);
    expect_ret(32'h7000, 32'h0000_0513, 1'b0, 4'd0, 32'h0, 32'h0000_A5A5, 1'b1);
    send(32'h7000, 32'h0000_0513, 1'b0, 4'd0, 32'hA5A5, 32'h0);
    expect_ret(32'h7004, 32'h0000_1583, 1'b0, 4'd0, 32'h0, 32'hFFFF_8001, 1'b1);
    send(32'h7004, 32'h0000_1583, 1'b0, 4'd0, 32'h0, 32'h106);
    resp(1'b1, 1'b0, 1'b0, 1'b0, 32'h8001_0000);
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
